// File: rtl/timer_periph_if.sv
// Bus port bundle for the timer peripheral.
// CPU-side chip select, direction, address, write data and read data.
interface timer_periph_if;
  logic        cs;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output cs, wr, addr, wdata,
    input  rdata
  );

  modport slave (
    input  cs, wr, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/timer_periph.sv
// Prescaled auto-reload timer with one-shot mode, W1C match flag and irq.
// Optional capture unit enabled by defining TIMER_CAPTURE_EN.
module timer_periph #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  timer_periph_if.slave  bus,
  output logic           irq,
  input  logic           capt_in
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             os_q, os_d;
  logic             ie_q, ie_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] arr_q, arr_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             match_q, match_d;
  logic             match_set;
  logic             capt_flag;
  logic [CNT_W-1:0] ccr;

  logic [2:0] sel;
  logic       we;
  logic       wr_tcr, wr_psc, wr_arr, wr_tsr;
  logic       clr, en_wr1, en_wr0;
  logic       hit;
  logic       unused_bits;

  assign sel    = bus.addr[4:2];
  assign we     = bus.cs & bus.wr;
  assign wr_tcr = we & (sel == 3'd0);
  assign wr_psc = we & (sel == 3'd1);
  assign wr_arr = we & (sel == 3'd2);
  assign wr_tsr = we & (sel == 3'd4);
  assign clr    = wr_tcr & bus.wdata[1];
  assign en_wr1 = wr_tcr & bus.wdata[0];
  assign en_wr0 = wr_tcr & ~bus.wdata[0];
  assign hit    = tcnt_q >= arr_q;

  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0],
                         bus.wdata[31:4]};

  // state and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      os_q    <= 1'b0;
      ie_q    <= 1'b0;
      psc_q   <= '0;
      pcnt_q  <= '0;
      arr_q   <= '0;
      tcnt_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      os_q    <= os_d;
      ie_q    <= ie_d;
      psc_q   <= psc_d;
      pcnt_q  <= pcnt_d;
      arr_q   <= arr_d;
      tcnt_q  <= tcnt_d;
      match_q <= match_d;
    end
  end

  // next state, counting and register writes; CLR overrides counting
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    os_d      = os_q;
    ie_d      = ie_q;
    psc_d     = psc_q;
    pcnt_d    = pcnt_q;
    arr_d     = arr_q;
    tcnt_d    = tcnt_q;
    match_set = 1'b0;

    if (wr_tcr) begin
      en_d = bus.wdata[0];
      os_d = bus.wdata[2];
      ie_d = bus.wdata[3];
    end
    if (wr_psc) psc_d = bus.wdata[PSC_W-1:0];
    if (wr_arr) arr_d = bus.wdata[CNT_W-1:0];

    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (en_wr1) state_d = RUN;
      end
      RUN: begin
        if (en_wr0) begin
          state_d = IDLE;
        end else if (pcnt_q == psc_q) begin
          pcnt_d = '0;
          if (hit) begin
            match_set = 1'b1;
            if (os_q && !en_wr1) begin
              en_d    = 1'b0;
              state_d = DONE;
            end else begin
              tcnt_d = '0;
            end
          end else begin
            tcnt_d = tcnt_q + CNT_W'(1);
          end
        end else begin
          pcnt_d = pcnt_q + PSC_W'(1);
        end
      end
      DONE: begin
        if (en_wr1) begin
          tcnt_d  = '0;
          pcnt_d  = '0;
          state_d = RUN;
        end else if (clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      tcnt_d    = '0;
      pcnt_d    = '0;
      match_set = 1'b0;
    end

    match_d = (match_q & ~(wr_tsr & bus.wdata[0])) | match_set;
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       sync_q;
  logic             capt_q;
  logic [CNT_W-1:0] ccr_q;
  logic             capt_rise;

  assign capt_rise = sync_q[1] & ~sync_q[2];
  assign capt_flag = capt_q;
  assign ccr       = ccr_q;

  // synchronizer, edge detect, capture register and CAPT flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      capt_q <= 1'b0;
      ccr_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], capt_in};
      capt_q <= (capt_q & ~(wr_tsr & bus.wdata[1])) | capt_rise;
      if (capt_rise) ccr_q <= tcnt_q;
    end
  end
`else
  logic unused_capt;

  assign unused_capt = capt_in;
  assign capt_flag   = 1'b0;
  assign ccr         = '0;
`endif

  assign irq = match_q & ie_q;

  // combinational read mux, independent of cs
  always_comb begin
    bus.rdata = '0;
    unique case (sel)
      3'd0:    bus.rdata = {28'b0, ie_q, os_q, 1'b0, en_q};
      3'd1:    bus.rdata = 32'(psc_q);
      3'd2:    bus.rdata = 32'(arr_q);
      3'd3:    bus.rdata = 32'(tcnt_q);
      3'd4:    bus.rdata = {30'b0, capt_flag, match_q};
      3'd5:    bus.rdata = 32'(ccr);
      default: bus.rdata = '0;
    endcase
  end

endmodule
